barrel_thread_sched: RTL

- Parametrised thread scheduler and per-thread PC file for the barrel RISC-V core.
- Replaces the fixed 8-thread rotation in fetch.
- Each cycle it issues one eligible hardware thread's PC to instruction memory and the F/D register. It skips inactive threads.
- A per-thread issue gap keeps each thread from having more than one instruction in the pipeline when few threads are active.
- Threads are started, stopped and redirected at runtime.

---
 rtl/barrel_thread_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/barrel_thread_sched.sv
// barrel_thread_sched: round-robin hardware-thread scheduler with per-thread PC file and issue gap
module barrel_thread_sched #(
    parameter int NUM_THREADS = 8,
    parameter int BITS_THREADS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    parameter int ADDRESS_WIDTH = 32,
    parameter int ISSUE_GAP = 5,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
    parameter logic [ADDRESS_WIDTH-1:0] PC_STRIDE = '0,
    parameter logic [NUM_THREADS-1:0] RESET_MASK = {NUM_THREADS{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     start_valid,
    input  logic [BITS_THREADS-1:0]  start_tid,
    input  logic [ADDRESS_WIDTH-1:0] start_pc,
    input  logic                     stop_valid,
    input  logic [BITS_THREADS-1:0]  stop_tid,
    input  logic                     redirect_valid,
    input  logic [BITS_THREADS-1:0]  redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     issue_valid,
    output logic [BITS_THREADS-1:0]  issue_tid,
    output logic [ADDRESS_WIDTH-1:0] issue_pc,
    output logic [ADDRESS_WIDTH-1:0] issue_pc_plus4,
    output logic [NUM_THREADS-1:0]   active_mask,
    output logic                     idle
);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 1);

    logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
    logic [GW-1:0]            gap_q [NUM_THREADS];
    logic [GW-1:0]            gap_d [NUM_THREADS];
    logic [NUM_THREADS-1:0]   active_q, active_d;
    logic                     idle_q, idle_d;
    logic [BITS_THREADS-1:0]  ptr_q, ptr_d;
    logic                     issue_valid_q, issue_valid_d;
    logic [BITS_THREADS-1:0]  issue_tid_q, issue_tid_d;
    logic [ADDRESS_WIDTH-1:0] issue_pc_q, issue_pc_d;
    logic [ADDRESS_WIDTH-1:0] issue_pc_plus4_q, issue_pc_plus4_d;
    logic [NUM_THREADS-1:0]   elig;
    logic                     sel_valid;
    logic [BITS_THREADS-1:0]  sel_tid;
    logic                     go;

    // eligibility: active and no instruction of this thread still in flight
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) elig[t] = active_q[t] && (gap_q[t] == '0);
    end

    // round-robin pick: first eligible tid after the last issued one, wrapping at NUM_THREADS-1
    always_comb begin
        sel_valid = 1'b0;
        sel_tid = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            if (!sel_valid && elig[(int'(ptr_q) + i) % NUM_THREADS]) begin
                sel_valid = 1'b1;
                sel_tid = BITS_THREADS'((int'(ptr_q) + i) % NUM_THREADS);
            end
        end
    end

    // next state: issue registers, rotation, gap countdown, PC file and control updates
    always_comb begin
        go = !stall && sel_valid;
        issue_valid_d = stall ? issue_valid_q : sel_valid;
        issue_tid_d = go ? sel_tid : issue_tid_q;
        issue_pc_d = go ? pc_q[sel_tid] : issue_pc_q;
        issue_pc_plus4_d = go ? pc_q[sel_tid] + ADDRESS_WIDTH'(4) : issue_pc_plus4_q;
        ptr_d = go ? sel_tid : ptr_q;
        for (int t = 0; t < NUM_THREADS; t++) begin
            gap_d[t] = stall ? gap_q[t] :
                       (go && sel_tid == BITS_THREADS'(t)) ? GAP_LOAD :
                       (gap_q[t] != '0) ? gap_q[t] - GW'(1) : gap_q[t];
            pc_d[t] = (start_valid && start_tid == BITS_THREADS'(t)) ? start_pc :
                      (redirect_valid && redirect_tid == BITS_THREADS'(t)) ? redirect_pc :
                      (go && sel_tid == BITS_THREADS'(t)) ? pc_q[t] + ADDRESS_WIDTH'(4) : pc_q[t];
            active_d[t] = (stop_valid && stop_tid == BITS_THREADS'(t)) ? 1'b0 :
                          (start_valid && start_tid == BITS_THREADS'(t)) ? 1'b1 : active_q[t];
        end
        idle_d = (active_d == '0);
    end

    // state registers with synchronous reset to the per-thread reset PCs and mask
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= RESET_PC + ADDRESS_WIDTH'(t) * PC_STRIDE;
                gap_q[t] <= '0;
            end
            active_q <= RESET_MASK;
            idle_q <= (RESET_MASK == '0);
            ptr_q <= BITS_THREADS'(NUM_THREADS - 1);
            issue_valid_q <= 1'b0;
            issue_tid_q <= '0;
            issue_pc_q <= '0;
            issue_pc_plus4_q <= '0;
        end else begin
            pc_q <= pc_d;
            gap_q <= gap_d;
            active_q <= active_d;
            idle_q <= idle_d;
            ptr_q <= ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_tid_q <= issue_tid_d;
            issue_pc_q <= issue_pc_d;
            issue_pc_plus4_q <= issue_pc_plus4_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_tid = issue_tid_q;
    assign issue_pc = issue_pc_q;
    assign issue_pc_plus4 = issue_pc_plus4_q;
    assign active_mask = active_q;
    assign idle = idle_q;
endmodule
